// File: rtl/burst_slave_pkg.sv
// Package for the burst bus slave.
// Holds the FSM state encoding, the bus mode constants and helpers that
// turn field widths into bus-beat counts for a given lane width.
package burst_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ADDR       = 3'd1,
    ST_LEN        = 3'd2,
    ST_WDATA      = 3'd3,
    ST_SPLIT_WAIT = 3'd4,
    ST_GRANT_WAIT = 3'd5,
    ST_RDRD       = 3'd6,
    ST_RDATA      = 3'd7
  } state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Beats needed to move the address field.
  function automatic int addr_beats(input int addr_width, input int lane_w);
    return addr_width / lane_w;
  endfunction

  // Beats needed to move the length field.
  function automatic int len_beats(input int burst_width, input int lane_w);
    return burst_width / lane_w;
  endfunction

  // Beats needed to move one data word.
  function automatic int data_beats(input int data_width, input int lane_w);
    return data_width / lane_w;
  endfunction

endpackage

// File: rtl/burst_slave_mem.sv
// slave_mem_bank: single-port memory bank with synchronous write, registered
// read and a register mirroring the word at DEBUG_ADDR.
// Ports:
//   clk_i, rst_i   clock, async active-high reset (debug mirror only)
//   we_i           write strobe for addr_i/wdata_i
//   addr_i         shared read/write word address
//   wdata_i        write word
//   rdata_o        word at addr_i from the previous cycle
//   debug_o        copy of mem[DEBUG_ADDR], updated with the write itself
module slave_mem_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int DEBUG_ADDR = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [DATA_WIDTH-1:0] debug_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] debug_q;

  // Memory array and registered read port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  // Debug mirror tracks every commit to DEBUG_ADDR.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      debug_q <= '0;
    end else if (we_i && (addr_i == ADDR_WIDTH'(DEBUG_ADDR))) begin
      debug_q <= wdata_i;
    end else begin
      debug_q <= debug_q;
    end
  end

  assign rdata_o = rdata_q;
  assign debug_o = debug_q;

endmodule

// File: rtl/burst_slave.sv
// burst_slave: serial-bus slave with LSB-first lanes of LANE_W bits, bursts of
// 1..2**BURST_WIDTH words with wrapping address increment, and an optional
// split read path with a programmable hold-off before the grant is honoured.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   bwdata_i          header / write beat, LSB-first
//   bmode_i           1 = write, 0 = read (taken from the first address beat)
//   bwvalid_i         beat valid; counts only while sready_o = 1
//   brdata_o          read beat, LSB-first
//   brvalid_o         brdata_o valid
//   sready_o          slave accepts header or write beats
//   split_grant_i     level grant to resume a split read
//   ssplit_o          one-cycle split indication
//   debug_led_out_o   copy of mem[DEBUG_ADDR]
module burst_slave
  import burst_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int LANE_W      = 1,
  parameter int BURST_WIDTH = 4,
  parameter int SPLIT_EN    = 0,
  parameter int SPLIT_DELAY = 4,
  parameter int DEBUG_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [LANE_W-1:0]     bwdata_i,
  input  logic                  bmode_i,
  input  logic                  bwvalid_i,
  output logic [LANE_W-1:0]     brdata_o,
  output logic                  brvalid_o,
  output logic                  sready_o,
  input  logic                  split_grant_i,
  output logic                  ssplit_o,
  output logic [DATA_WIDTH-1:0] debug_led_out_o
);

  localparam int ADDR_BEATS = addr_beats(ADDR_WIDTH, LANE_W);
  localparam int LEN_BEATS  = len_beats(BURST_WIDTH, LANE_W);
  localparam int DATA_BEATS = data_beats(DATA_WIDTH, LANE_W);

  localparam logic [15:0] ADDR_LAST  = 16'(ADDR_BEATS - 1);
  localparam logic [15:0] LEN_LAST   = 16'(LEN_BEATS - 1);
  localparam logic [15:0] DATA_LAST  = 16'(DATA_BEATS - 1);
  localparam logic [15:0] SPLIT_LAST = 16'(SPLIT_DELAY - 1);

  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BURST_WIDTH-1:0] len_q, len_d;
  logic [15:0]            beat_q, beat_d;
  logic [15:0]            split_q, split_d;
  logic [DATA_WIDTH-1:0]  wsh_q, wsh_d;
  logic [DATA_WIDTH-1:0]  rsh_q, rsh_d;
  logic [LANE_W-1:0]      brdata_q, brdata_d;
  logic                   brvalid_q, brvalid_d;
  logic                   ssplit_q, ssplit_d;
  logic                   sready_q, sready_d;

  logic                   fire;
  logic                   mem_we;
  logic                   load;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic [ADDR_WIDTH-1:0]  addr_shift;
  logic [BURST_WIDTH-1:0] len_shift;
  logic [DATA_WIDTH-1:0]  word_shift;

  assign fire = bwvalid_i & sready_q;

  // Fields arrive LSB-first: each beat enters at the top and moves down.
  assign addr_shift = (addr_q >> LANE_W) | (ADDR_WIDTH'(bwdata_i) << (ADDR_WIDTH - LANE_W));
  assign len_shift  = (len_q >> LANE_W) | (BURST_WIDTH'(bwdata_i) << (BURST_WIDTH - LANE_W));
  assign word_shift = (wsh_q >> LANE_W) | (DATA_WIDTH'(bwdata_i) << (DATA_WIDTH - LANE_W));

  // The read port always looks at addr_q, except on a word load where addr_q
  // is about to advance: fetching addr_q+1 then keeps words gap-free even
  // when a word is a single beat.
  assign mem_addr = load ? (addr_q + ADDR_WIDTH'(1)) : addr_q;

  slave_mem_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEBUG_ADDR(DEBUG_ADDR)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (word_shift),
    .rdata_o (mem_rdata),
    .debug_o (debug_led_out_o)
  );

  // Next-state and datapath control for the frame FSM.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    split_d   = split_q;
    wsh_d     = wsh_q;
    rsh_d     = rsh_q;
    brdata_d  = brdata_q;
    brvalid_d = brvalid_q;
    ssplit_d  = 1'b0;
    mem_we    = 1'b0;
    load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          mode_d = bmode_i;
          addr_d = addr_shift;
          if (ADDR_BEATS == 1) begin
            state_d = ST_LEN;
            beat_d  = 16'd0;
          end else begin
            state_d = ST_ADDR;
            beat_d  = 16'd1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ADDR: begin
        if (fire) begin
          addr_d = addr_shift;
          if (beat_q == ADDR_LAST) begin
            state_d = ST_LEN;
            beat_d  = 16'd0;
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end else begin
          state_d = ST_ADDR;
        end
      end

      ST_LEN: begin
        if (fire) begin
          len_d = len_shift;
          if (beat_q == LEN_LAST) begin
            beat_d = 16'd0;
            if (mode_q == MODE_WRITE) begin
              state_d = ST_WDATA;
            end else if (SPLIT_EN != 0) begin
              ssplit_d = 1'b1;
              split_d  = 16'd0;
              state_d  = (SPLIT_DELAY == 0) ? ST_GRANT_WAIT : ST_SPLIT_WAIT;
            end else begin
              state_d = ST_RDRD;
            end
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end else begin
          state_d = ST_LEN;
        end
      end

      ST_WDATA: begin
        if (fire) begin
          wsh_d = word_shift;
          if (beat_q == DATA_LAST) begin
            // Whole word present: commit it now; partial words never reach memory.
            mem_we = 1'b1;
            addr_d = addr_q + ADDR_WIDTH'(1);
            beat_d = 16'd0;
            if (len_q == '0) begin
              state_d = ST_IDLE;
            end else begin
              len_d = len_q - BURST_WIDTH'(1);
            end
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end else begin
          state_d = ST_WDATA;
        end
      end

      ST_SPLIT_WAIT: begin
        // The grant is not looked at until the hold-off has elapsed.
        if (split_q == SPLIT_LAST) begin
          state_d = ST_GRANT_WAIT;
        end else begin
          split_d = split_q + 16'd1;
        end
      end

      ST_GRANT_WAIT: begin
        if (split_grant_i) begin
          state_d = ST_RDRD;
        end else begin
          state_d = ST_GRANT_WAIT;
        end
      end

      ST_RDRD: begin
        // First word is already on the registered read port.
        load    = 1'b1;
        state_d = ST_RDATA;
      end

      ST_RDATA: begin
        if (beat_q == DATA_LAST) begin
          if (len_q != '0) begin
            load  = 1'b1;
            len_d = len_q - BURST_WIDTH'(1);
          end else begin
            brvalid_d = 1'b0;
            brdata_d  = '0;
            state_d   = ST_IDLE;
          end
        end else begin
          brdata_d = rsh_q[LANE_W-1:0];
          rsh_d    = rsh_q >> LANE_W;
          beat_d   = beat_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      brdata_d  = mem_rdata[LANE_W-1:0];
      rsh_d     = mem_rdata >> LANE_W;
      brvalid_d = 1'b1;
      beat_d    = 16'd0;
      addr_d    = addr_q + ADDR_WIDTH'(1);
    end else begin
      rsh_d = rsh_d;
    end

    sready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) ||
               (state_d == ST_LEN)  || (state_d == ST_WDATA);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_READ;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= 16'd0;
      split_q   <= 16'd0;
      wsh_q     <= '0;
      rsh_q     <= '0;
      brdata_q  <= '0;
      brvalid_q <= 1'b0;
      ssplit_q  <= 1'b0;
      sready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      split_q   <= split_d;
      wsh_q     <= wsh_d;
      rsh_q     <= rsh_d;
      brdata_q  <= brdata_d;
      brvalid_q <= brvalid_d;
      ssplit_q  <= ssplit_d;
      sready_q  <= sready_d;
    end
  end

  assign brdata_o  = brdata_q;
  assign brvalid_o = brvalid_q;
  assign ssplit_o  = ssplit_q;
  assign sready_o  = sready_q;

endmodule

// File: tb/tb_burst_slave.sv
// Bench for burst_slave: three instances (default, split with delay 4, LANE_W=4)
// driven by directed steps with random data, checked against a word-level
// memory model and frame-timing arithmetic.
module tb_burst_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] bwdata  [3];
  logic       bmode   [3];
  logic       bwvalid [3];
  logic       grant   [3];

  wire        brd0, brd1;
  wire [3:0]  brd2;
  wire [2:0]  brv, srdy, ssp;
  wire [7:0]  dbg0, dbg1, dbg2;

  int n_chk;
  int n_fail;

  logic [7:0] model   [3][4096];
  logic [7:0] dbg_mdl [3];
  logic [7:0] wbuf    [16];

  burst_slave dut0 (
    .clk_i(clk), .rst_i(rst), .bwdata_i(bwdata[0][0:0]), .bmode_i(bmode[0]),
    .bwvalid_i(bwvalid[0]), .brdata_o(brd0), .brvalid_o(brv[0]), .sready_o(srdy[0]),
    .split_grant_i(grant[0]), .ssplit_o(ssp[0]), .debug_led_out_o(dbg0)
  );

  burst_slave #(.SPLIT_EN(1), .SPLIT_DELAY(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .bwdata_i(bwdata[1][0:0]), .bmode_i(bmode[1]),
    .bwvalid_i(bwvalid[1]), .brdata_o(brd1), .brvalid_o(brv[1]), .sready_o(srdy[1]),
    .split_grant_i(grant[1]), .ssplit_o(ssp[1]), .debug_led_out_o(dbg1)
  );

  burst_slave #(.LANE_W(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .bwdata_i(bwdata[2]), .bmode_i(bmode[2]),
    .bwvalid_i(bwvalid[2]), .brdata_o(brd2), .brvalid_o(brv[2]), .sready_o(srdy[2]),
    .split_grant_i(grant[2]), .ssplit_o(ssp[2]), .debug_led_out_o(dbg2)
  );

  function automatic int lw(input int d);
    return (d == 2) ? 4 : 1;
  endfunction

  function automatic logic [3:0] get_brd(input int d);
    case (d)
      0:       return {3'b000, brd0};
      1:       return {3'b000, brd1};
      default: return brd2;
    endcase
  endfunction

  function automatic logic [7:0] get_dbg(input int d);
    case (d)
      0:       return dbg0;
      1:       return dbg1;
      default: return dbg2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One beat, driven at a negedge and sampled by the next posedge.
  task automatic send(input int d, input logic [3:0] v, input logic m);
    chk("beat sready", 32'(srdy[d]), 32'd1);
    bwdata[d]  = v;
    bmode[d]   = m;
    bwvalid[d] = 1'b1;
    @(negedge clk);
    bwvalid[d] = 1'b0;
    bwdata[d]  = 4'h0;
  endtask

  task automatic idle_chk(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      chk("stall sready", 32'(srdy[d]), 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic send_field(input int d, input logic [31:0] val, input int width,
                            input logic m, input int gap_pos, input int gap_n);
    logic [31:0] mask;
    mask = (32'd1 << lw(d)) - 32'd1;
    for (int b = 0; b < width / lw(d); b++) begin
      if (b == gap_pos) idle_chk(d, gap_n);
      send(d, 4'((val >> (b * lw(d))) & mask), m);
    end
  endtask

  // Write wbuf[0..len] starting at addr; optional stalls in address and first word.
  task automatic write_frame(input int d, input logic [11:0] addr, input int len,
                             input int ga_pos, input int ga_n, input int gd_pos, input int gd_n);
    logic [11:0] a;
    send_field(d, 32'(addr), 12, 1'b1, ga_pos, ga_n);
    send_field(d, 32'(len), 4, 1'b1, -1, 0);
    for (int i = 0; i <= len; i++) begin
      send_field(d, 32'(wbuf[i]), 8, 1'b1, (i == 0) ? gd_pos : -1, gd_n);
    end
    for (int i = 0; i <= len; i++) begin
      a = addr + 12'(i);
      model[d][a] = wbuf[i];
      if (a == 12'h000) dbg_mdl[d] = wbuf[i];
    end
    chk("debug mirror", 32'(get_dbg(d)), 32'(dbg_mdl[d]));
  endtask

  // Read len+1 words; for the split instance the grant rises gstart cycles after the last header beat.
  task automatic read_frame(input int d, input logic [11:0] addr, input int len, input int gstart);
    int          first;
    logic [11:0] a;
    logic [31:0] mask;
    logic [31:0] val;
    mask = (32'd1 << lw(d)) - 32'd1;
    send_field(d, 32'(addr), 12, 1'b0, -1, 0);
    send_field(d, 32'(len), 4, 1'b0, -1, 0);
    if (d == 1) first = ((gstart > 5) ? gstart : 5) + 2;
    else        first = 2;
    for (int off = 1; off < first; off++) begin
      if (d == 1 && off == gstart) grant[d] = 1'b1;
      chk("pre-data brvalid", 32'(brv[d]), 32'd0);
      chk("ssplit pulse", 32'(ssp[d]), 32'((d == 1) && (off == 1)));
      chk("busy sready", 32'(srdy[d]), 32'd0);
      @(negedge clk);
    end
    for (int w = 0; w <= len; w++) begin
      a   = addr + 12'(w);
      val = 32'(model[d][a]);
      for (int b = 0; b < 8 / lw(d); b++) begin
        chk("rd brvalid", 32'(brv[d]), 32'd1);
        chk("rd brdata", 32'(get_brd(d)), (val >> (b * lw(d))) & mask);
        @(negedge clk);
      end
    end
    chk("end brvalid", 32'(brv[d]), 32'd0);
    chk("end sready", 32'(srdy[d]), 32'd1);
    grant[d] = 1'b0;
  endtask

  initial begin
    logic [11:0] raddr;
    int          rlen;
    n_chk  = 0;
    n_fail = 0;
    for (int d = 0; d < 3; d++) begin
      bwdata[d]  = 4'h0;
      bmode[d]   = 1'b0;
      bwvalid[d] = 1'b0;
      grant[d]   = 1'b0;
      dbg_mdl[d] = 8'h00;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset brvalid", 32'(brv[d]), 32'd0);
      chk("reset ssplit", 32'(ssp[d]), 32'd0);
      chk("reset sready", 32'(srdy[d]), 32'd1);
      chk("reset brdata", 32'(get_brd(d)), 32'd0);
      chk("reset debug", 32'(get_dbg(d)), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Write then read back a two-word burst.
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    write_frame(0, 12'h010, 1, -1, 0, -1, 0);
    read_frame(0, 12'h010, 1, 0);

    // Address wrap on write and on read.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_frame(0, 12'hFFF, 1, -1, 0, -1, 0);
    read_frame(0, 12'hFFF, 0, 0);
    read_frame(0, 12'h000, 0, 0);
    read_frame(0, 12'hFFF, 1, 0);

    // Stalls mid-address and mid-data give the same memory image.
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    write_frame(0, 12'h100, 1, 5, 3, 4, 2);
    write_frame(0, 12'h200, 1, -1, 0, -1, 0);
    read_frame(0, 12'h100, 1, 0);
    read_frame(0, 12'h200, 1, 0);

    // Debug mirror.
    wbuf[0] = 8'h5A;
    write_frame(0, 12'h000, 0, -1, 0, -1, 0);

    // Random back-to-back bursts.
    for (int it = 0; it < 6; it++) begin
      raddr = 12'($urandom);
      rlen  = int'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
      write_frame(0, raddr, rlen, -1, 0, -1, 0);
      read_frame(0, raddr, rlen, 0);
    end

    // Reset during the second word of a burst.
    wbuf[0] = 8'hEE;
    write_frame(0, 12'h301, 0, -1, 0, -1, 0);
    wbuf[0] = 8'($urandom);
    send_field(0, 32'h300, 12, 1'b1, -1, 0);
    send_field(0, 32'd1, 4, 1'b1, -1, 0);
    send_field(0, 32'(wbuf[0]), 8, 1'b1, -1, 0);
    send(0, 4'h1, 1'b1);
    send(0, 4'h0, 1'b1);
    send(0, 4'h1, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid-reset brvalid", 32'(brv[0]), 32'd0);
    chk("mid-reset ssplit", 32'(ssp[0]), 32'd0);
    chk("mid-reset sready", 32'(srdy[0]), 32'd1);
    chk("mid-reset brdata", 32'(get_brd(0)), 32'd0);
    chk("mid-reset debug", 32'(get_dbg(0)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model[0][12'h300] = wbuf[0];
    for (int d = 0; d < 3; d++) dbg_mdl[d] = 8'h00;
    @(negedge clk);
    read_frame(0, 12'h300, 1, 0);

    // Split reads: early grant, late grant, random grant.
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    write_frame(1, 12'h010, 1, -1, 0, -1, 0);
    read_frame(1, 12'h010, 1, 2);
    read_frame(1, 12'h010, 0, 8);
    read_frame(1, 12'h011, 0, 1);
    for (int it = 0; it < 3; it++) begin
      raddr = 12'($urandom);
      rlen  = int'($urandom_range(0, 2));
      for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
      write_frame(1, raddr, rlen, -1, 0, -1, 0);
      read_frame(1, raddr, rlen, int'($urandom_range(1, 9)));
    end

    // Four-bit lanes.
    wbuf[0] = 8'hC3;
    write_frame(2, 12'h010, 0, -1, 0, -1, 0);
    read_frame(2, 12'h010, 0, 0);
    for (int it = 0; it < 3; it++) begin
      raddr = 12'($urandom);
      rlen  = int'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
      write_frame(2, raddr, rlen, -1, 0, -1, 0);
      read_frame(2, raddr, rlen, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_slave.md
# burst_slave

Parametrised bus slave for the serial system bus. It generalises the single-word slave in three ways: a configurable lane width (LANE_W bits per beat), multi-word bursts with address auto-increment, and a split read path with a programmable delay. It sits behind the bus interconnect on one slave port, owns its memory bank, and mirrors one debug word onto LEDs.

## Interface
- ADDR_WIDTH, 12: word address width; memory depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8: word width.
- LANE_W, 1: bits per bus beat. ADDR_WIDTH, DATA_WIDTH and BURST_WIDTH must each be a multiple of LANE_W.
- BURST_WIDTH, 4: width of the length field; a burst is 1..2**BURST_WIDTH words.
- SPLIT_EN, 0: 1 means reads are split, 0 means reads are answered directly.
- SPLIT_DELAY, 4: cycles held in split before a grant is honoured (0 allowed).
- DEBUG_ADDR, 0: word address mirrored on debug_led_out.
---
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- bwdata  in  LANE_W  write/header beat, LSB-first.
- bmode  in  1  1 = write, 0 = read; sampled on the first address beat.
- bwvalid  in  1  beat valid on bwdata.
- brdata  out  LANE_W  read beat, LSB-first.
- brvalid  out  1  brdata valid.
- sready  out  1  slave can accept header or write beats.
- split_grant  in  1  level grant to resume a split read.
- ssplit  out  1  one-cycle split pulse.
- debug_led_out  out  DATA_WIDTH  copy of mem[DEBUG_ADDR].

## Operation
- **Frame format:** address (ADDR_WIDTH/LANE_W beats), then length field len = words−1 (BURST_WIDTH/LANE_W beats). For writes, (len+1)×DATA_WIDTH/LANE_W data beats follow.
- **Beat counting:** a beat counts only on a cycle with bwvalid=1 while sready=1. When bwvalid=0 mid-frame, the slave stalls and holds all state; there is no timeout.
- **States:** IDLE → ADDR (entered on the first valid beat, which also latches bmode) → LEN.
  - Write path: LEN → WDATA → IDLE.
  - Read path: LEN → SPLIT_WAIT (SPLIT_EN=1) or RDRD (SPLIT_EN=0).
  - Split path: SPLIT_WAIT → GRANT_WAIT → RDRD → RDATA → IDLE.
- **Write:** each word is committed on the cycle after its last beat. A partial word is never written. The address increments per word and wraps modulo 2**ADDR_WIDTH.
- **Read:** memory read is registered (1 cycle). Words stream back-to-back with brvalid=1 on every beat, with no gap between words; the next word is prefetched. There is no read backpressure. The address wraps as for writes.
- **Split:**
  - ssplit pulses for 1 cycle on entry to SPLIT_WAIT.
  - The slave waits SPLIT_DELAY cycles, then samples split_grant each cycle in GRANT_WAIT.
  - A grant asserted during SPLIT_WAIT is ignored until the delay expires. SPLIT_DELAY=0 enters GRANT_WAIT directly.
- **sready:** 1 in IDLE, ADDR, LEN and WDATA; 0 otherwise.
- **debug_led_out:** a register updated in the same cycle as any commit to DEBUG_ADDR.

## Timing
- **Reset values:** brdata=0, brvalid=0, ssplit=0, sready=1, debug_led_out=0, state=IDLE. Memory contents are not reset.
- **Reset mid-operation:** the block returns to IDLE at once. Words already committed persist; the in-flight word is dropped.
- **Non-split read:** last LEN beat at cycle t → first brvalid at t+2.
- **Split read:** last LEN beat at t → ssplit at t+1 → grant sampled at cycle g ≥ t+1+SPLIT_DELAY → first brvalid at g+2.
- **Write:** last beat of a word at t → memory written at t+1 → debug_led_out updated at t+1 when the address matches.
- **Return to IDLE:** sready returns to 1 on the cycle after the last brvalid beat. A write's last data beat and a new frame's first beat may be back-to-back (cycle t+1).

## Structure
- **Package burst_slave_pkg:**
  - state enum;
  - mode constants MODE_READ=0 and MODE_WRITE=1;
  - derived beat counts ADDR_BEATS, LEN_BEATS and DATA_BEATS as functions of the parameters.
- **Sub-module slave_mem_bank:**
  - single-port, synchronous write, registered read;
  - holds the debug mirror register;
  - parameters DATA_WIDTH, ADDR_WIDTH and DEBUG_ADDR.
- **burst_slave:** holds the FSM, the shift/deshift registers, and the beat, word and split counters.

## Test plan
- **Write then read (defaults):** write addr 0x010, len=1, data 0xA5, 0x3C; then read addr 0x010, len=1 → brdata yields 0xA5 then 0x3C LSB-first, over 16 consecutive brvalid cycles, first beat at t+2.
- **Split read (SPLIT_EN=1, SPLIT_DELAY=4):**
  - read addr 0x010 → ssplit high exactly 1 cycle and sready=0;
  - grant held from t+2 → not honoured before t+5;
  - data begins 2 cycles after the grant is sampled.
- **Wrap:** write addr 0xFFF, len=1, data 0x11, 0x22 → mem[0xFFF]=0x11 and mem[0x000]=0x22.
- **Stall:** bwvalid dropped for 3 cycles mid-address and for 2 cycles mid-data → identical memory result; sready stays 1.
- **Debug and reset:**
  - write 0x5A to DEBUG_ADDR → debug_led_out=0x5A one cycle after the last beat;
  - reset asserted during the 2nd word of a burst → word 1 is committed, word 2 is absent, outputs go to their reset values.
- **LANE_W=4:** write 0xC3 then read it back → 2 beats per word, brdata beats 0x3 then 0xC.
